// File: rtl/uart_burst_input_handler.sv
// uart_burst_input_handler: parses 'L'+hex command/address/count header and a burst of hex data words
module uart_burst_input_handler #(
  parameter int CMD_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8,
  parameter int MAX_WORDS   = 16,
  parameter int TIMEOUT     = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   byte_available_i,
  input  logic [7:0]             byte_i,
  output logic [CMD_WIDTH-1:0]   command_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic [COUNT_WIDTH-1:0] word_count_o,
  output logic                   header_ready_o,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   data_valid_o,
  output logic [COUNT_WIDTH-1:0] data_index_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   timeout_o,
  output logic                   busy_o
);
  localparam int CD = CMD_WIDTH / 4;
  localparam int AD = ADDR_WIDTH / 4;
  localparam int DD = DATA_WIDTH / 4;
  localparam int KD = COUNT_WIDTH / 4;
  localparam int MD = CD > AD ? (CD > DD ? (CD > KD ? CD : KD) : (DD > KD ? DD : KD)) : (AD > DD ? (AD > KD ? AD : KD) : (DD > KD ? DD : KD));
  localparam int NW = $clog2(MD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, COUNT, DATA} state_t;
  state_t state_q;
  logic [NW-1:0] nib_q;
  logic [TW-1:0] tmo_q;
  logic [COUNT_WIDTH-1:0] widx_q;
  logic hex;
  logic last;
  logic [3:0] nib;
  logic [NW-1:0] lim;
  logic [COUNT_WIDTH-1:0] cnt_d;
  assign busy_o = state_q != IDLE;
  // Decode the incoming character and spot the final digit of the current field
  always_comb begin
    hex = byte_i inside {["0":"9"], ["A":"F"], ["a":"f"]};
    nib = byte_i <= "9" ? byte_i[3:0] : byte_i[3:0] + 4'd9;
    lim = state_q == CMD ? NW'(CD - 1) : state_q == ADDR ? NW'(AD - 1) : state_q == COUNT ? NW'(KD - 1) : NW'(DD - 1);
    last = nib_q == lim;
    cnt_d = (word_count_o << 4) | COUNT_WIDTH'(nib);
  end
  // Packet FSM: field shifting, registered pulses and inter-byte timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      nib_q <= '0;
      tmo_q <= '0;
      widx_q <= '0;
      command_o <= '0;
      address_o <= '0;
      word_count_o <= '0;
      data_o <= '0;
      data_index_o <= '0;
      header_ready_o <= 1'b0;
      data_valid_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      header_ready_o <= 1'b0;
      data_valid_o <= 1'b0;
      done_o <= 1'b0;
      error_o <= 1'b0;
      timeout_o <= 1'b0;
      if (state_q == IDLE) begin
        tmo_q <= '0;
        nib_q <= '0;
        if (byte_available_i && byte_i == "L") state_q <= CMD;
      end else if (byte_available_i) begin
        tmo_q <= '0;
        if (!hex) begin
          error_o <= 1'b1;
          nib_q <= '0;
          state_q <= byte_i == "L" ? CMD : IDLE;
        end else begin
          nib_q <= last ? '0 : nib_q + 1'b1;
          case (state_q)
            CMD: begin
              command_o <= (command_o << 4) | CMD_WIDTH'(nib);
              if (last) state_q <= ADDR;
            end
            ADDR: begin
              address_o <= (address_o << 4) | ADDR_WIDTH'(nib);
              if (last) state_q <= COUNT;
            end
            COUNT: begin
              word_count_o <= cnt_d;
              if (last) begin
                if (cnt_d > COUNT_WIDTH'(MAX_WORDS)) begin
                  error_o <= 1'b1;
                  state_q <= IDLE;
                end else begin
                  header_ready_o <= 1'b1;
                  widx_q <= '0;
                  data_index_o <= '0;
                  done_o <= cnt_d == '0;
                  state_q <= cnt_d == '0 ? IDLE : DATA;
                end
              end
            end
            DATA: begin
              data_o <= (data_o << 4) | DATA_WIDTH'(nib);
              if (last) begin
                data_valid_o <= 1'b1;
                data_index_o <= widx_q;
                widx_q <= widx_q + 1'b1;
                done_o <= widx_q == word_count_o - 1'b1;
                if (widx_q == word_count_o - 1'b1) state_q <= IDLE;
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        timeout_o <= 1'b1;
        tmo_q <= '0;
        state_q <= IDLE;
      end else begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end
endmodule
